// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg: shared constants, state/grant encodings and the round-robin pick helper
//   TEXT_BASE_ADDRESS : byte address of instruction word 0
//   IMA_*             : FSM state and grant-owner encodings
//   arb_pick()        : {valid, owner} from the two eligibility flags and the last grant
package imem_arbiter_pkg;

    localparam logic [31:0] TEXT_BASE_ADDRESS = 32'h0040_0000;

    localparam logic [1:0] IMA_IDLE   = 2'd0;
    localparam logic [1:0] IMA_ACCESS = 2'd1;
    localparam logic [1:0] IMA_RESP   = 2'd2;

    localparam logic IMA_GNT_FETCH  = 1'b0;
    localparam logic IMA_GNT_LOADER = 1'b1;

    typedef struct packed {
        logic valid;
        logic owner;
    } grant_t;

    // When both are eligible the one that did not win last time gets it.
    function automatic grant_t arb_pick(input logic f_ok, input logic l_ok, input logic last);
        grant_t g;
        g.valid = f_ok | l_ok;
        g.owner = (f_ok & l_ok) ? ~last : l_ok;
        return g;
    endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// imem_arbiter_if: fetch, loader and memory-array signals of the instruction-memory arbiter
//   master : requesters and memory array (drive requests and mem_rdata)
//   slave  : the arbiter (drives acks, read data, errors, memory controls, busy)
interface imem_arbiter_if #(parameter int IDX_W = 10);

    logic             f_req;
    logic [31:0]      f_addr;
    logic             f_ack;
    logic [31:0]      f_rdata;
    logic             f_err;
    logic             l_req;
    logic             l_we;
    logic [31:0]      l_addr;
    logic [31:0]      l_wdata;
    logic             l_lock;
    logic             l_ack;
    logic [31:0]      l_rdata;
    logic             l_err;
    logic [IDX_W-1:0] mem_idx;
    logic             mem_we;
    logic [31:0]      mem_wdata;
    logic [31:0]      mem_rdata;
    logic             busy;

    modport master (
        output f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        input  f_ack, f_rdata, f_err, l_ack, l_rdata, l_err, mem_idx, mem_we, mem_wdata, busy
    );

    modport slave (
        input  f_req, f_addr, l_req, l_we, l_addr, l_wdata, l_lock, mem_rdata,
        output f_ack, f_rdata, f_err, l_ack, l_rdata, l_err, mem_idx, mem_we, mem_wdata, busy
    );

endinterface

// File: rtl/imem_addr_check.sv
// imem_addr_check: byte address -> word index plus misaligned/out-of-range error
//   addr_i : byte address
//   idx_o  : word index (addr_i - TEXT_BASE) / 4, truncated to IDX_W bits
//   err_o  : 1 when misaligned or offset >= 4 * 2**IDX_W (addresses below TEXT_BASE wrap and fail)
module imem_addr_check
    import imem_arbiter_pkg::*;
#(
    parameter int          IDX_W     = 10,
    parameter logic [31:0] TEXT_BASE = TEXT_BASE_ADDRESS
) (
    input  logic [31:0]      addr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             err_o
);

    logic [31:0] off;

    // TEXT_BASE is word aligned, so the offset's low bits equal the address's low bits.
    assign off   = addr_i - TEXT_BASE;
    assign idx_o = off[IDX_W+1:2];
    assign err_o = (off[1:0] != 2'b00) | (off[31:IDX_W+2] != '0);

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction memory between fetch and loader
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of imem_arbiter_if
//              f_*   fetch requester (read only), f_ack one-cycle pulse with f_rdata/f_err
//              l_*   loader requester (read/write), l_lock masks fetch requests
//              mem_* word index, write strobe/data and combinational read data of the array
//              busy  1 whenever the FSM is not idle
module imem_arbiter
    import imem_arbiter_pkg::*;
#(
    parameter int          IDX_W     = 10,
    parameter logic [31:0] TEXT_BASE = TEXT_BASE_ADDRESS
) (
    input  logic            clk,
    input  logic            rst,
    imem_arbiter_if.slave   bus
);

    logic [1:0]       state_q, state_d;
    logic             last_q, owner_q, we_q, err_q;
    logic [IDX_W-1:0] idx_q;
    logic [31:0]      wdata_q, f_rdata_q, l_rdata_q;
    logic             f_err_q, l_err_q;
    logic             in_access, in_resp, f_ok, l_ok, take;
    grant_t           gnt;
    logic [31:0]      sel_addr, acc_rdata;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_err;

    imem_addr_check #(.IDX_W(IDX_W), .TEXT_BASE(TEXT_BASE)) u_addr_check (
        .addr_i (sel_addr),
        .idx_o  (sel_idx),
        .err_o  (sel_err)
    );

    // In RESP the owner's req still belongs to the transaction being acked,
    // so it is not eligible until the following cycle.
    always_comb begin
        in_access = state_q == IMA_ACCESS;
        in_resp   = state_q == IMA_RESP;
        f_ok      = bus.f_req & ~bus.l_lock & ~(in_resp & (owner_q == IMA_GNT_FETCH));
        l_ok      = bus.l_req & ~(in_resp & (owner_q == IMA_GNT_LOADER));
        gnt       = arb_pick(f_ok, l_ok, last_q);
        take      = ~in_access & gnt.valid;
        sel_addr  = (gnt.owner == IMA_GNT_LOADER) ? bus.l_addr : bus.f_addr;
        state_d   = in_access ? IMA_RESP : (gnt.valid ? IMA_ACCESS : IMA_IDLE);
        acc_rdata = (we_q | err_q) ? '0 : bus.mem_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IMA_IDLE;
            last_q    <= IMA_GNT_LOADER;
            owner_q   <= IMA_GNT_FETCH;
            we_q      <= 1'b0;
            err_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            f_rdata_q <= '0;
            f_err_q   <= 1'b0;
            l_rdata_q <= '0;
            l_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (take) begin
                last_q  <= gnt.owner;
                owner_q <= gnt.owner;
                we_q    <= (gnt.owner == IMA_GNT_LOADER) & bus.l_we;
                err_q   <= sel_err;
                idx_q   <= sel_idx;
                wdata_q <= bus.l_wdata;
            end
            if (in_access & (owner_q == IMA_GNT_FETCH)) begin
                f_rdata_q <= acc_rdata;
                f_err_q   <= err_q;
            end
            if (in_access & (owner_q == IMA_GNT_LOADER)) begin
                l_rdata_q <= acc_rdata;
                l_err_q   <= err_q;
            end
        end
    end

    assign bus.f_ack     = in_resp & (owner_q == IMA_GNT_FETCH);
    assign bus.l_ack     = in_resp & (owner_q == IMA_GNT_LOADER);
    assign bus.f_rdata   = f_rdata_q;
    assign bus.f_err     = f_err_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.l_err     = l_err_q;
    assign bus.mem_idx   = idx_q;
    assign bus.mem_we    = in_access & we_q & ~err_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.busy      = state_q != IMA_IDLE;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: table vectors, hand-written timing sequences and random transactions
module tb_imem_arbiter;
    import imem_arbiter_pkg::*;

    localparam int          IDX_W = 10;
    localparam logic [31:0] TB    = TEXT_BASE_ADDRESS;

    typedef struct {
        bit          ld;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        bit          exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int fails = 0;
    int we_pulses = 0;
    logic [IDX_W-1:0] we_idx = '0;
    logic [31:0] mem [1024];
    logic [31:0] ref_mem [1024];
    logic [31:0] exp_last_f = '0;
    logic [31:0] exp_last_l = '0;
    vec_t vt [12];

    imem_arbiter_if #(.IDX_W(IDX_W)) bus();

    imem_arbiter #(.IDX_W(IDX_W), .TEXT_BASE(TB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_idx];

    always @(posedge clk) if (bus.mem_we) mem[bus.mem_idx] <= bus.mem_wdata;

    always @(negedge clk) begin
        if (bus.mem_we) begin
            we_pulses++;
            we_idx = bus.mem_idx;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] init_val(int i);
        return (i == 5) ? 32'h2402_0001 : 32'hA500_0000 + 32'(i);
    endfunction

    function automatic bit ref_err(logic [31:0] a);
        logic [31:0] off;
        off = a - TB;
        return (a % 4 != 0) || (off >= 32'd4096);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " f_ack"}, 32'(bus.f_ack), 0);
        chk({tag, " l_ack"}, 32'(bus.l_ack), 0);
        chk({tag, " f_rdata"}, bus.f_rdata, 0);
        chk({tag, " l_rdata"}, bus.l_rdata, 0);
        chk({tag, " f_err"}, 32'(bus.f_err), 0);
        chk({tag, " l_err"}, 32'(bus.l_err), 0);
        chk({tag, " mem_idx"}, 32'(bus.mem_idx), 0);
        chk({tag, " mem_we"}, 32'(bus.mem_we), 0);
        chk({tag, " mem_wdata"}, bus.mem_wdata, 0);
        chk({tag, " busy"}, 32'(bus.busy), 0);
    endtask

    // One transaction from an idle arbiter; lat counts cycles from the request cycle to ack.
    task automatic txn(input bit ld, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        if (ld) begin
            bus.l_req = 1'b1; bus.l_we = we; bus.l_addr = addr; bus.l_wdata = wdata;
        end else begin
            bus.f_req = 1'b1; bus.f_addr = addr;
        end
        lat = -1; rd = 'x; er = 1'bx;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if ((ld ? bus.l_ack : bus.f_ack) === 1'b1) begin
                lat = c;
                rd = ld ? bus.l_rdata : bus.f_rdata;
                er = ld ? bus.l_err : bus.f_err;
                break;
            end
        end
        bus.l_req = 1'b0;
        bus.f_req = 1'b0;
    endtask

    task automatic apply(input string tag, input bit ld, input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
        logic [31:0] rd, off;
        logic er;
        int lat, p0;
        bit wr;
        p0 = we_pulses;
        wr = ld && we && !exp_err;
        off = addr - TB;
        txn(ld, we, addr, wdata, rd, er, lat);
        chk({tag, " latency"}, lat, 2);
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, 32'(er), 32'(exp_err));
        chk({tag, " we_pulses"}, we_pulses - p0, wr ? 1 : 0);
        if (wr) begin
            chk({tag, " we_idx"}, 32'(we_idx), off / 4);
            ref_mem[off / 4] = wdata;
        end
        chk({tag, " other_hold"}, ld ? bus.f_rdata : bus.l_rdata, ld ? exp_last_f : exp_last_l);
        if (ld) exp_last_l = exp_rd; else exp_last_f = exp_rd;
    endtask

    initial begin
        logic [31:0] addr, off, exp_rd;
        bit ld, we, er;
        int p0, r;

        for (int i = 0; i < 1024; i++) begin
            mem[i] = init_val(i);
            ref_mem[i] = init_val(i);
        end
        bus.f_req = 0; bus.f_addr = 0; bus.l_req = 0; bus.l_we = 0;
        bus.l_addr = 0; bus.l_wdata = 0; bus.l_lock = 0;

        repeat (2) @(negedge clk);
        check_zero("reset");
        @(posedge clk); #1 rst = 1'b0;

        vt[0]  = '{0, 0, TB + 20,   0,            32'h2402_0001, 0};
        vt[1]  = '{1, 1, TB + 8,    32'hDEAD_BEEF, 0,            0};
        vt[2]  = '{0, 0, TB + 8,    0,            32'hDEAD_BEEF, 0};
        vt[3]  = '{0, 0, TB + 2,    0,            0,             1};
        vt[4]  = '{0, 0, TB + 4096, 0,            0,             1};
        vt[5]  = '{0, 0, TB - 4,    0,            0,             1};
        vt[6]  = '{1, 1, TB + 4096, 32'h1234_5678, 0,            1};
        vt[7]  = '{1, 0, TB + 8,    0,            32'hDEAD_BEEF, 0};
        vt[8]  = '{1, 0, TB + 4092, 0,            32'hA500_03FF, 0};
        vt[9]  = '{0, 0, TB + 4092, 0,            32'hA500_03FF, 0};
        vt[10] = '{1, 1, TB + 1,    32'h5555_AAAA, 0,            1};
        vt[11] = '{0, 0, TB,        0,            32'hA500_0000, 0};
        for (int i = 0; i < 12; i++)
            apply($sformatf("vec%0d", i), vt[i].ld, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].exp_rd, vt[i].exp_err);

        // reset during the ACCESS cycle of a loader write
        p0 = we_pulses;
        @(negedge clk);
        bus.l_req = 1; bus.l_we = 1; bus.l_addr = TB + 16; bus.l_wdata = 32'h1111_1111;
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        bus.l_req = 0; bus.l_we = 0;
        check_zero("rst_mid");
        @(posedge clk); #1 rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("rst_mid no_ack", 32'(bus.l_ack), 0);
        end
        chk("rst_mid we_pulses", we_pulses - p0, 0);
        chk("rst_mid mem4", mem[4], ref_mem[4]);
        exp_last_f = 0; exp_last_l = 0;

        // contention after reset: grants F, L, F, L, an ack every second cycle
        @(negedge clk);
        bus.f_req = 1; bus.f_addr = TB + 20; bus.l_req = 1; bus.l_we = 0; bus.l_addr = TB + 8;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("rr c%0d f_ack", c), 32'(bus.f_ack), (c % 4 == 2) ? 1 : 0);
            chk($sformatf("rr c%0d l_ack", c), 32'(bus.l_ack), (c % 4 == 0) ? 1 : 0);
            chk($sformatf("rr c%0d busy", c), 32'(bus.busy), 1);
            if (bus.f_ack) chk("rr f_rdata", bus.f_rdata, ref_mem[5]);
            if (bus.l_ack) chk("rr l_rdata", bus.l_rdata, ref_mem[2]);
            if (c == 8) begin bus.f_req = 0; bus.l_req = 0; end
        end
        @(negedge clk);
        chk("rr idle busy", 32'(bus.busy), 0);

        // l_lock masks fetch; the lone loader is re-granted one cycle after each ack
        bus.l_lock = 1; bus.f_req = 1; bus.l_req = 1;
        r = -1;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c <= 8) begin
                chk($sformatf("lock c%0d f_ack", c), 32'(bus.f_ack), 0);
                chk($sformatf("lock c%0d l_ack", c), 32'(bus.l_ack), (c % 3 == 2) ? 1 : 0);
                chk($sformatf("lock c%0d busy", c), 32'(bus.busy), (c % 3 == 0) ? 0 : 1);
            end
            if (c == 8) begin bus.l_req = 0; bus.l_lock = 0; end
            if (c > 8 && bus.f_ack === 1'b1 && r < 0) begin
                r = c;
                chk("unlock f_rdata", bus.f_rdata, ref_mem[5]);
                bus.f_req = 0;
            end
        end
        chk("unlock f_ack cycle", r, 10);
        bus.f_req = 0;

        // loader alone holding l_req for three reads
        @(negedge clk);
        bus.l_req = 1; bus.l_we = 0; bus.l_addr = TB;
        r = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk($sformatf("b2b c%0d l_ack", c), 32'(bus.l_ack), (c % 3 == 2) ? 1 : 0);
            if (bus.l_ack === 1'b1) begin
                chk($sformatf("b2b read%0d", r), bus.l_rdata, ref_mem[r]);
                r++;
                bus.l_addr = TB + 32'(4 * r);
            end
        end
        bus.l_req = 0;
        exp_last_l = ref_mem[2];
        exp_last_f = ref_mem[5];

        // random single transactions against the reference memory
        for (int i = 0; i < 80; i++) begin
            ld = 1'($urandom_range(0, 1));
            we = ld & 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            if (r < 7)       addr = TB + 32'(4 * $urandom_range(0, 1023));
            else if (r == 7) addr = TB + 32'(4 * $urandom_range(0, 1023)) + 32'($urandom_range(1, 3));
            else if (r == 8) addr = TB + 32'd4096 + 32'(4 * $urandom_range(0, 1023));
            else             addr = TB - 32'(4 * $urandom_range(1, 64));
            er = ref_err(addr);
            off = addr - TB;
            exp_rd = (er || we) ? 32'd0 : ref_mem[off / 4];
            apply($sformatf("rnd%0d", i), ld, we, addr, $urandom, exp_rd, er);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
        $finish;
    end

endmodule
